serial_adder: RTL and testbench

- Bit-serial WIDTH-bit adder. It is the addition counterpart of the team's combinational ripple-borrow subtractor.
- Operands are captured on a start pulse and summed LSB-first, one bit per clock, through a single full-adder cell and a carry flip-flop.
- A one-cycle done pulse is issued when the result is ready.
- Used in datapath labs wherever area matters more than latency.

---
 rtl/serial_adder_pkg.sv | 8 +
 rtl/serial_adder_if.sv | 34 +++
 rtl/serial_adder_full_adder_cell.sv | 13 +
 rtl/serial_adder.sv | 84 ++++++++
 tb/tb_serial_adder.sv | 135 +++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared constants and FSM state type for the bit-serial adder
package serial_adder_pkg;
    localparam int DEFAULT_WIDTH = 4;
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle between a requester and serial_adder
//   start, c_in, A, B (and sub when SERIAL_ADDER_SUB_EN) : requester -> adder
//   busy, done, S, c_out                                  : adder -> requester
interface serial_adder_if
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             start;
    logic             c_in;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] S;
    logic             c_out;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub;
`endif
    modport master (
`ifdef SERIAL_ADDER_SUB_EN
        output sub,
`endif
        output start, c_in, A, B,
        input  busy, done, S, c_out
    );
    modport slave (
`ifdef SERIAL_ADDER_SUB_EN
        input  sub,
`endif
        input  start, c_in, A, B,
        output busy, done, S, c_out
    );
endinterface

// File: rtl/serial_adder_full_adder_cell.sv
// full_adder_cell: one-bit combinational full adder
//   a, b, cin : addend bits and carry-in
//   s, cout   : sum bit and majority carry-out
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder, LSB first, one bit per clock
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : serial_adder_if.slave (start/c_in/A/B in, busy/done/S/c_out out)
//   SERIAL_ADDER_SUB_EN adds bus.sub: 1 computes A - B - c_in, c_out is the borrow
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    serial_adder_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, s_r, b_load;
    logic [CW-1:0]    cnt;
    logic             carry, c_load, s_bit, c_nx, c_res, c_out_r, done_r, last, accept;
`ifdef SERIAL_ADDER_SUB_EN
    logic             sub_r;
    // subtraction is A + ~B + ~borrow_in; the final carry is the inverted borrow
    assign b_load = bus.sub ? ~bus.B : bus.B;
    assign c_load = bus.sub ^ bus.c_in;
    assign c_res  = sub_r ^ c_nx;
`else
    assign b_load = bus.B;
    assign c_load = bus.c_in;
    assign c_res  = c_nx;
`endif
    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (s_bit),
        .cout (c_nx)
    );
    always_comb begin
        last     = cnt == CW'(WIDTH - 1);
        accept   = state == ST_IDLE && bus.start;
        state_nx = accept ? ST_RUN : (state == ST_RUN && last) ? ST_IDLE : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            a_sr    <= '0;
            b_sr    <= '0;
            s_r     <= '0;
            cnt     <= '0;
            carry   <= 1'b0;
            c_out_r <= 1'b0;
            done_r  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            sub_r   <= 1'b0;
`endif
        end else begin
            state  <= state_nx;
            done_r <= 1'b0;
            if (accept) begin
                a_sr  <= bus.A;
                b_sr  <= b_load;
                carry <= c_load;
                cnt   <= '0;
`ifdef SERIAL_ADDER_SUB_EN
                sub_r <= bus.sub;
`endif
            end else if (state == ST_RUN) begin
                // sum bits enter at the MSB so S is aligned after WIDTH shifts
                s_r   <= {s_bit, s_r[WIDTH-1:1]};
                a_sr  <= a_sr >> 1;
                b_sr  <= b_sr >> 1;
                carry <= c_nx;
                cnt   <= last ? cnt : cnt + CW'(1);
                if (last) begin
                    done_r  <= 1'b1;
                    c_out_r <= c_res;
                end
            end
        end
    end
    assign bus.busy  = state == ST_RUN;
    assign bus.done  = done_r;
    assign bus.S     = s_r;
    assign bus.c_out = c_out_r;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed ops against an arithmetic reference model
module tb_serial_adder;
    localparam int W = 4;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    logic [W-1:0] last_s = '0;
    logic last_c = 1'b0;
    serial_adder_if #(.WIDTH(W)) bus();
    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic set_sub(input logic sb);
`ifdef SERIAL_ADDER_SUB_EN
        bus.sub = sb;
`endif
    endtask
    // caller is positioned #1 after an edge; this op's start is sampled on the next edge
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, input bit noise);
        int e;
        int busy_n;
        int full;
        bus.A = a;
        bus.B = b;
        bus.c_in = ci;
        set_sub(sb);
        bus.start = 1'b1;
        full = sb ? int'(a) - int'(b) - int'(ci) : int'(a) + int'(b) + int'(ci);
        @(posedge clk); #1;
        check("done_drop", bus.done, 0);
        e = 0;
        busy_n = 0;
        while (!bus.done && e < 3 * W) begin
            busy_n += bus.busy;
            bus.start = noise ? 1'($urandom) : 1'b0;
            bus.A = W'($urandom);
            bus.B = W'($urandom);
            bus.c_in = 1'($urandom);
            set_sub(1'($urandom));
            @(posedge clk); #1;
            e++;
        end
        check("latency", e, W);
        check("busy_cycles", busy_n, W);
        check("busy_at_done", bus.busy, 0);
        last_s = W'(full);
        last_c = sb ? (full < 0) : (full >= (1 << W));
        check("sum", bus.S, last_s);
        check("c_out", bus.c_out, last_c);
    endtask
    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            check("done_low", bus.done, 0);
            check("busy_low", bus.busy, 0);
            check("hold_s", bus.S, last_s);
            check("hold_c", bus.c_out, last_c);
        end
    endtask
    initial begin
        bus.start = 1'b0;
        bus.A = '0;
        bus.B = '0;
        bus.c_in = 1'b0;
        set_sub(1'b0);
        #12;
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_s", bus.S, 0);
        check("rst_c", bus.c_out, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        idle(2);
        do_op(4'h7, 4'h5, 1'b0, 1'b0, 1'b0);
        check("d1_s", bus.S, 4'hC);
        idle(1);
        do_op(4'hF, 4'h1, 1'b0, 1'b0, 1'b0);
        check("d2_c", bus.c_out, 1);
        idle(1);
        do_op(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        check("d3_s", bus.S, 4'hF);
        idle(1);
        do_op(4'h2, 4'h3, 1'b0, 1'b0, 1'b1);
        check("d4_s", bus.S, 4'h5);
        do_op(4'h9, 4'h9, 1'b0, 1'b0, 1'b0);
        check("d5_s", bus.S, 4'h2);
        idle(2);
        bus.A = 4'h2;
        bus.B = 4'h3;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_s", bus.S, 0);
        check("abort_c", bus.c_out, 0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        last_s = '0;
        last_c = 1'b0;
        idle(W + 2);
        do_op(4'h6, 4'hB, 1'b1, 1'b0, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
        idle(1);
        do_op(4'h3, 4'h5, 1'b0, 1'b1, 1'b0);
        check("sub1", {bus.c_out, bus.S}, 5'h1E);
        do_op(4'h9, 4'h4, 1'b1, 1'b1, 1'b0);
        check("sub2", {bus.c_out, bus.S}, 5'h04);
`endif
        for (int i = 0; i < 60; i++) begin
`ifdef SERIAL_ADDER_SUB_EN
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
`else
            do_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1'($urandom));
`endif
            if ($urandom_range(0, 1) == 0) idle($urandom_range(1, 3));
        end
        idle(1);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
